interrupt_sequencer: RTL
========================

// Module: interrupt_sequencer
// PURPOSE
//  Sequences CPU entry into and exit from nested, prioritised interrupts. Latches requests,
//  picks the highest unmasked pending level above the one in service, and redirects the PC
//  to that level's vector. Saves and restores the preempted PC/level on an internal stack.
//  Sits between the Interrupt request logic and the PC/fetch stage.
// PARAMETERS
//  NUM_IRQ        3             number of interrupt levels; index = priority (higher wins)
//  PC_WIDTH       32            PC / vector width
//  VECTOR_BASE    32'h0000_0100 vector of level 0
//  VECTOR_STRIDE  32'h10        byte distance between consecutive level vectors
// PORTS
//  clock            in   1         single clock, rising edge
//  resetN           in   1         asynchronous, active-low reset
//  irqRequest       in   NUM_IRQ   request pulses/levels; rising edge latched as pending
//  irqMask          in   NUM_IRQ   1 = level masked (stays pending, not taken)
//  globalEnable     in   1         0 = no new entries; returns still honoured
//  pipeStall        in   1         1 = PC stage cannot accept a redirect this cycle
//  currentPc        in   PC_WIDTH  resume PC pushed on entry
//  eret             in   1         return-from-interrupt retired (1-cycle pulse)
//  redirect         out  1         1-cycle pulse: load redirectPc into PC
//  redirectPc       out  PC_WIDTH  vector on entry, popped PC on return
//  activeLevel      out  NUM_IRQ   one-hot level in service; 0 = none
//  nestDepth        out  2         number of stacked frames (0..NUM_IRQ)
//  interrupted      out  1         1-cycle pulse on each entry
//  interruptReturned out 1         1-cycle pulse on each return
//  eretError        out  1         1-cycle pulse: eret with nestDepth==0
// BEHAVIOUR
//  Reset: every output 0, pending 0, stack empty, state RUN.
//  Pending: bit i is set on the rising edge of irqRequest[i] and cleared when level i is entered.
//   If set and clear coincide, set wins.
//  Eligible: pending & ~irqMask, with priority > the current priority (-1 when idle), and globalEnable=1.
//  FSM states RUN, ENTER, RETURN:
//   RUN    -> RETURN if eret (checked before eligibility; eret wins a tie).
//          -> ENTER if any level is eligible. The winner is the highest index, latched at the transition.
//   ENTER  wait while pipeStall. Then in one cycle: push {currentPc, activeLevel},
//          redirect=1, redirectPc=VECTOR_BASE+idx*VECTOR_STRIDE, activeLevel=1<<idx,
//          nestDepth+1, interrupted=1, clear pending[idx] -> RUN.
//   RETURN wait while pipeStall. Then in one cycle: pop, redirect=1, redirectPc=saved PC,
//          activeLevel=saved level, nestDepth-1, interruptReturned=1 -> RUN.
//  Latency: request edge at cycle N gives an ENTER transition at N+1 and redirect at N+2 (no stall).
//  Eligibility is re-evaluated only in RUN, so at least one RUN cycle separates back-to-back entries.
//  Stack depth is NUM_IRQ. Strictly increasing priority makes overflow impossible; an
//   overflow condition is an assertion failure.
//  eret at depth 0: no state change, eretError=1 for 1 cycle, stay in RUN.
//  eret arriving in ENTER/RETURN: ignored (the CPU cannot retire it then); this is a bench assertion.
//  Same-level re-request while that level is in service: held pending, taken only after return
//   lowers the priority.
//  Masking a level mid-service has no effect on activeLevel.
//  resetN low at any time: immediate clear to the reset state; no redirect is issued.
// STRUCTURE
//  Package irq_pkg: state enum {RUN,ENTER,RETURN}; function vector_of(idx); width localparams.
//  Sub-module irq_priority_enc: combinational highest-set-bit encoder over NUM_IRQ bits,
//   giving {valid, idx}.
//  Stack: register arrays of PC_WIDTH+NUM_IRQ bits with a top pointer = nestDepth.
// TESTING
//  1 Nest up: req 001 @pc 0x40, then 010 @0x104, then 100 @0x114 -> redirects 0x100, 0x110, 0x120;
//    nestDepth 1,2,3; activeLevel 001,010,100.
//  2 Unwind: three erets -> redirectPc 0x114, 0x104, 0x40; activeLevel 010, 001, 000;
//    interruptReturned x3; nestDepth returns to 0.
//  3 Priority blocking: in service at 100, req 010 then 001 -> no redirect.
//    eret -> return to the saved PC, then enter 010 (0x110); after its eret, enter 001.
//  4 Stall/tie: pipeStall=1 for 4 cycles during ENTER -> redirect delayed exactly 4 cycles.
//    eret and req 100 in the same RUN cycle -> return first, then entry.
//  5 Edge cases: eret when idle -> eretError=1, outputs unchanged. Masked req 010 stays pending,
//    is taken 2 cycles after unmask. globalEnable=0 blocks entry.
//  6 Reset mid-ENTER: resetN low for 1 cycle -> all outputs 0 asynchronously, pending cleared,
//    no redirect after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types, default widths and the vector address helper for the interrupt sequencer.
package irq_pkg;

    localparam int unsigned NUM_IRQ_DEF = 3;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned DEPTH_W     = 2;

    localparam logic [PC_W-1:0] VECTOR_BASE_DEF   = 32'h0000_0100;
    localparam logic [PC_W-1:0] VECTOR_STRIDE_DEF = 32'h0000_0010;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    // Entry address of interrupt level idx.
    function automatic logic [PC_W-1:0] vector_of(input int unsigned     idx,
                                                  input logic [PC_W-1:0] base,
                                                  input logic [PC_W-1:0] stride);
        return base + PC_W'(idx) * stride;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Highest-set-bit encoder: reports whether any bit is set and the index of the highest one.
module irq_priority_enc #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     bits,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Later iterations override earlier ones, so the highest index wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (bits[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Nested prioritised interrupt entry/exit sequencer: latches requests, redirects the PC to
// level vectors and restores the preempted PC/level from an internal frame stack on eret.
module interrupt_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned         NUM_IRQ       = NUM_IRQ_DEF,
    parameter int unsigned         PC_WIDTH      = PC_W,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = PC_WIDTH'(VECTOR_BASE_DEF),
    parameter logic [PC_WIDTH-1:0] VECTOR_STRIDE = PC_WIDTH'(VECTOR_STRIDE_DEF)
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic [NUM_IRQ-1:0]  irqRequest,
    input  logic [NUM_IRQ-1:0]  irqMask,
    input  logic                globalEnable,
    input  logic                pipeStall,
    input  logic [PC_WIDTH-1:0] currentPc,
    input  logic                eret,
    output logic                redirect,
    output logic [PC_WIDTH-1:0] redirectPc,
    output logic [NUM_IRQ-1:0]  activeLevel,
    output logic [DEPTH_W-1:0]  nestDepth,
    output logic                interrupted,
    output logic                interruptReturned,
    output logic                eretError
);

    localparam int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned FRAME_W = PC_WIDTH + NUM_IRQ;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]     win_idx_q, win_idx_d;
    logic [FRAME_W-1:0]   stack_q [NUM_IRQ];
    logic [DEPTH_W-1:0]   top_ptr;
    logic                 push;

    logic                 redirect_d, interrupted_d, returned_d, eret_error_d;
    logic [PC_WIDTH-1:0]  redirect_pc_d;
    logic [NUM_IRQ-1:0]   active_d;
    logic [DEPTH_W-1:0]   depth_d;

    logic [NUM_IRQ-1:0]   above, eligible;
    logic                 act_valid, elig_valid;
    logic [IDX_W-1:0]     act_idx, elig_idx;

    irq_priority_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_act_enc (
        .bits  (activeLevel),
        .valid (act_valid),
        .idx   (act_idx)
    );

    // Only levels strictly above the one in service may preempt it.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            above[i] = !act_valid || (IDX_W'(i) > act_idx);
        end
    end

    assign eligible = pending_q & ~irqMask & above & {NUM_IRQ{globalEnable}};

    irq_priority_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_elig_enc (
        .bits  (eligible),
        .valid (elig_valid),
        .idx   (elig_idx)
    );

    assign top_ptr = nestDepth - DEPTH_W'(1);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Next state, next outputs, pending bookkeeping and stack push/pop.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        win_idx_d     = win_idx_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirectPc;
        active_d      = activeLevel;
        depth_d       = nestDepth;
        interrupted_d = 1'b0;
        returned_d    = 1'b0;
        eret_error_d  = 1'b0;
        push          = 1'b0;

        case (state_q)
            RUN: begin
                if (eret) begin
                    if (nestDepth == '0) eret_error_d = 1'b1;
                    else                 state_d      = RETURN;
                end else if (elig_valid) begin
                    state_d   = ENTER;
                    win_idx_d = elig_idx;
                end
            end
            ENTER: begin
                if (!pipeStall) begin
                    push                 = 1'b1;
                    redirect_d           = 1'b1;
                    redirect_pc_d        = PC_WIDTH'(vector_of(int'(win_idx_q),
                                                               PC_W'(VECTOR_BASE),
                                                               PC_W'(VECTOR_STRIDE)));
                    active_d             = NUM_IRQ'(1) << win_idx_q;
                    depth_d              = nestDepth + DEPTH_W'(1);
                    interrupted_d        = 1'b1;
                    pending_d[win_idx_q] = 1'b0;
                    state_d              = RUN;
                end
            end
            RETURN: begin
                if (!pipeStall) begin
                    {redirect_pc_d, active_d} = stack_q[top_ptr];
                    redirect_d                = 1'b1;
                    depth_d                   = nestDepth - DEPTH_W'(1);
                    returned_d                = 1'b1;
                    state_d                   = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // A new rising edge beats a clear in the same cycle.
        pending_d = pending_d | (irqRequest & ~irq_prev_q);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            irq_prev_q        <= '0;
            pending_q         <= '0;
            win_idx_q         <= '0;
            redirect          <= 1'b0;
            redirectPc        <= '0;
            activeLevel       <= '0;
            nestDepth         <= '0;
            interrupted       <= 1'b0;
            interruptReturned <= 1'b0;
            eretError         <= 1'b0;
        end else begin
            irq_prev_q        <= irqRequest;
            pending_q         <= pending_d;
            win_idx_q         <= win_idx_d;
            redirect          <= redirect_d;
            redirectPc        <= redirect_pc_d;
            activeLevel       <= active_d;
            nestDepth         <= depth_d;
            interrupted       <= interrupted_d;
            interruptReturned <= returned_d;
            eretError         <= eret_error_d;
        end
    end

    // Frame storage needs no reset: nestDepth alone marks which entries are live.
    always_ff @(posedge clock) begin
        if (push) stack_q[nestDepth] <= {currentPc, activeLevel};
    end

    a_no_overflow : assert property (@(posedge clock) disable iff (!resetN)
        !(state_q == ENTER && !pipeStall && nestDepth == DEPTH_W'(NUM_IRQ)));

endmodule
